dmem_responder: RTL and testbench

- Data-memory responder (slave) serving the load/store requests that the pipeline's memory stage issues.
- Accepts one request at a time over a valid/ready handshake.
- Applies byte-lane writes and returns read data after a configurable wait-state latency.
- Returns the result over a valid/ready response channel.
- Stands in for the combinational data memory once the core supports memory stalls.

---
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the memory stage (master) and the data memory (slave)
//   req_valid/req_ready : request handshake, req_* fields valid while req_valid=1
//   req_addr  [31:0]    : byte address
//   req_wdata [31:0]    : store data
//   req_wmask [3:0]     : byte-lane write enables, bit i covers wdata[8i+7:8i]
//   req_write/req_read  : request class (write wins when both are set, neither = null request)
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata [31:0]    : load data, 0 for stores, null requests and errors
//   rsp_error           : out-of-range (or misaligned) request
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        req_write;
   logic        req_read;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   modport master (
      output req_valid, req_addr, req_wdata, req_wmask, req_write, req_read, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );
   modport slave (
      input  req_valid, req_addr, req_wdata, req_wmask, req_write, req_read, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave with byte-lane writes and LATENCY wait states per request
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (memory contents are kept)
//   bus   : dmem_responder_if.slave, one outstanding request at a time
// Optional build macro DMEM_MISALIGN_CHECK_EN: reads/writes with req_addr[1:0]!=0 complete with
// rsp_error=1, rsp_rdata=0 and no write. Without it the low address bits are ignored.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);
   localparam int         AW  = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wmask_q, wmask_d;
   logic          wr_q, wr_d;
   logic          rd_q, rd_d;
   logic          bad_q, bad_d;
   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   mem [DEPTH_WORDS];
   logic          oor;
   logic          mis;
   logic          commit;

   // any address bit above the word index makes the request out of range
   assign oor = (bus.req_addr >> (AW + 2)) != 32'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
   assign mis = (bus.req_write | bus.req_read) & (bus.req_addr[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   // the access happens on the edge that leaves WAIT; an abandoned WAIT never gets here
   assign commit = (state_q == WAIT) && (cnt_q == 4'd0) && wr_q && !bad_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      bad_d       = bad_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      unique case (state_q)
         IDLE: if (bus.req_valid) begin
            idx_d       = bus.req_addr[AW+1:2];
            wdata_d     = bus.req_wdata;
            wmask_d     = bus.req_wmask;
            wr_d        = bus.req_write;
            rd_d        = bus.req_read & ~bus.req_write;
            bad_d       = oor | mis;
            cnt_d       = LAT;
            req_ready_d = 1'b0;
            state_d     = WAIT;
         end
         WAIT: if (cnt_q == 4'd0) begin
            rsp_valid_d = 1'b1;
            err_d       = bad_q;
            rdata_d     = (rd_q && !bad_q) ? mem[idx_q] : 32'd0;
            state_d     = RESP;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         RESP: if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            rdata_d     = 32'd0;
            err_d       = 1'b0;
            req_ready_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         idx_q       <= '0;
         wdata_q     <= 32'd0;
         wmask_q     <= 4'd0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         bad_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         bad_q       <= bad_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk)
      if (commit)
         for (int i = 0; i < 4; i++)
            if (wmask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_error = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder (LATENCY=2 main instance, LATENCY=0 second instance)
module tb_dmem_responder;
   logic        clk;
   logic        reset;
   logic        v, sel, wr, rd, rr;
   logic [31:0] addr, wdata;
   logic [3:0]  wmask;
   int          errors, checks;

   dmem_responder_if b ();
   dmem_responder_if b0 ();

   assign b.req_valid  = v & ~sel;
   assign b0.req_valid = v & sel;
   assign b.req_addr   = addr;
   assign b0.req_addr  = addr;
   assign b.req_wdata  = wdata;
   assign b0.req_wdata = wdata;
   assign b.req_wmask  = wmask;
   assign b0.req_wmask = wmask;
   assign b.req_write  = wr;
   assign b0.req_write = wr;
   assign b.req_read   = rd;
   assign b0.req_read  = rd;
   assign b.rsp_ready  = rr;
   assign b0.rsp_ready = rr;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(b));
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // one full transaction with rsp_ready high; lat counts edges from acceptance to rsp_valid
   task automatic xact(input logic s, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       output logic [31:0] rdat, output logic er, output int lat);
      int n;
      @(negedge clk);
      sel = s; wr = w; rd = r; addr = a; wdata = d; wmask = m; rr = 1'b1; v = 1'b1;
      n = 0;
      while (!(s ? b0.req_ready : b.req_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      v = 1'b0; addr = $urandom; wdata = $urandom; wmask = 4'($urandom); wr = 1'($urandom); rd = 1'($urandom);
      lat = 0;
      while (!(s ? b0.rsp_valid : b.rsp_valid) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rdat = s ? b0.rsp_rdata : b.rsp_rdata;
      er   = s ? b0.rsp_error : b.rsp_error;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (b.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", b.req_ready); end
      checks++; if (b.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", b.rsp_valid); end
      checks++; if (b.rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", b.rsp_rdata); end
      checks++; if (b.rsp_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", b.rsp_error); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_write_read;
      logic [31:0] rdat; logic er; int lat;
      xact(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, rdat, er, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_error: got %b expected 0", er); end
      checks++; if (rdat !== 32'd0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", rdat); end
      xact(0, 0, 1, 32'h10, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
      checks++; if (rdat !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rdat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_error: got %b expected 0", er); end
   endtask

   task automatic test_partial;
      logic [31:0] rdat; logic er; int lat;
      xact(0, 1, 0, 32'h20, 32'h11223344, 4'hF, rdat, er, lat);
      xact(0, 1, 0, 32'h20, 32'hAABBCCDD, 4'b0101, rdat, er, lat);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL partial_wr_error: got %b expected 0", er); end
      xact(0, 0, 1, 32'h20, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (rdat !== 32'h11BB33DD) begin errors++; $display("FAIL partial_data: got %h expected 11bb33dd", rdat); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rdat; logic er; int lat;
      xact(0, 0, 1, 32'h10, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (b.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp: got %b expected 0", b.req_ready); end
      @(negedge clk);
      checks++; if (b.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", b.rsp_valid); end
      checks++; if (b.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b expected 1", b.req_ready); end
      checks++; if (b.rsp_rdata !== 32'd0) begin errors++; $display("FAIL b2b_rdata_clear: got %h expected 0", b.rsp_rdata); end
      checks++; if (b.rsp_error !== 1'b0) begin errors++; $display("FAIL b2b_error_clear: got %b expected 0", b.rsp_error); end
      xact(0, 0, 1, 32'h20, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (rdat !== 32'h11BB33DD) begin errors++; $display("FAIL b2b_second_data: got %h expected 11bb33dd", rdat); end
   endtask

   task automatic test_backpressure;
      int n;
      @(negedge clk);
      sel = 1'b0; wr = 1'b0; rd = 1'b1; addr = 32'h20; wmask = 4'h0; rr = 1'b0; v = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v = 1'b0; addr = $urandom;
      n = 0;
      while (!b.rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 6; i++) begin
         checks++; if (b.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, b.rsp_valid); end
         checks++; if (b.rsp_rdata !== 32'h11BB33DD) begin errors++; $display("FAIL bp_rdata[%0d]: got %h expected 11bb33dd", i, b.rsp_rdata); end
         checks++; if (b.rsp_error !== 1'b0) begin errors++; $display("FAIL bp_error[%0d]: got %b expected 0", i, b.rsp_error); end
         checks++; if (b.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, b.req_ready); end
         @(negedge clk);
      end
      rr = 1'b1;
      @(negedge clk);
      checks++; if (b.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", b.rsp_valid); end
      checks++; if (b.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", b.req_ready); end
   endtask

   task automatic test_out_of_range;
      logic [31:0] rdat; logic er; int lat;
      xact(0, 1, 0, 32'h0, 32'h12345678, 4'hF, rdat, er, lat);
      xact(0, 1, 0, 32'h1000, 32'h5, 4'hF, rdat, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_error: got %b expected 1", er); end
      checks++; if (rdat !== 32'd0) begin errors++; $display("FAIL oor_wr_rdata: got %h expected 0", rdat); end
      xact(0, 0, 1, 32'h0, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (rdat !== 32'h12345678) begin errors++; $display("FAIL oor_alias_data: got %h expected 12345678", rdat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL oor_alias_error: got %b expected 0", er); end
      xact(0, 0, 1, 32'h80000010, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_rd_error: got %b expected 1", er); end
      checks++; if (rdat !== 32'd0) begin errors++; $display("FAIL oor_rd_rdata: got %h expected 0", rdat); end
   endtask

   task automatic test_null_priority;
      logic [31:0] rdat; logic er; int lat;
      xact(0, 0, 0, 32'h10, 32'h0, 4'hF, rdat, er, lat);
      checks++; if (rdat !== 32'd0) begin errors++; $display("FAIL null_rdata: got %h expected 0", rdat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL null_error: got %b expected 0", er); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL null_latency: got %0d expected 3", lat); end
      xact(0, 1, 1, 32'h50, 32'h600DCAFE, 4'hF, rdat, er, lat);
      checks++; if (rdat !== 32'd0) begin errors++; $display("FAIL prio_rdata: got %h expected 0", rdat); end
      xact(0, 0, 1, 32'h50, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (rdat !== 32'h600DCAFE) begin errors++; $display("FAIL prio_readback: got %h expected 600dcafe", rdat); end
      xact(0, 1, 0, 32'h10, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL mask0_error: got %b expected 0", er); end
      xact(0, 0, 1, 32'h10, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (rdat !== 32'hDEADBEEF) begin errors++; $display("FAIL mask0_readback: got %h expected deadbeef", rdat); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] rdat; logic er; int lat;
      xact(0, 1, 0, 32'h40, 32'h0, 4'hF, rdat, er, lat);
      @(negedge clk);
      sel = 1'b0; wr = 1'b1; rd = 1'b0; addr = 32'h40; wdata = 32'hCAFE0000; wmask = 4'hF; rr = 1'b1; v = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v = 1'b0;
      reset = 1'b1;
      #1;
      checks++; if (b.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", b.req_ready); end
      checks++; if (b.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", b.rsp_valid); end
      checks++; if (b.rsp_rdata !== 32'd0) begin errors++; $display("FAIL midrst_rdata: got %h expected 0", b.rsp_rdata); end
      checks++; if (b.rsp_error !== 1'b0) begin errors++; $display("FAIL midrst_error: got %b expected 0", b.rsp_error); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      xact(0, 0, 1, 32'h40, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (rdat !== 32'd0) begin errors++; $display("FAIL midrst_dropped_write: got %h expected 0", rdat); end
      xact(0, 0, 1, 32'h50, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (rdat !== 32'h600DCAFE) begin errors++; $display("FAIL midrst_mem_kept: got %h expected 600dcafe", rdat); end
   endtask

   task automatic test_misalign;
      logic [31:0] rdat; logic er; int lat;
      logic        exp_err;
      logic [31:0] exp_word;
`ifdef DMEM_MISALIGN_CHECK_EN
      exp_err = 1'b1; exp_word = 32'h0;
`else
      exp_err = 1'b0; exp_word = 32'h0BADF00D;
`endif
      xact(0, 1, 0, 32'h42, 32'h0BADF00D, 4'hF, rdat, er, lat);
      checks++; if (er !== exp_err) begin errors++; $display("FAIL misalign_error: got %b expected %b", er, exp_err); end
      checks++; if (rdat !== 32'd0) begin errors++; $display("FAIL misalign_rdata: got %h expected 0", rdat); end
      xact(0, 0, 1, 32'h40, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (rdat !== exp_word) begin errors++; $display("FAIL misalign_word: got %h expected %h", rdat, exp_word); end
      xact(0, 0, 0, 32'h43, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL misalign_null: got %b expected 0", er); end
   endtask

   task automatic test_latency0;
      logic [31:0] rdat; logic er; int lat;
      xact(1, 1, 0, 32'h80, 32'h76543210, 4'hF, rdat, er, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL lat0_wr_latency: got %0d expected 1", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL lat0_wr_error: got %b expected 0", er); end
      xact(1, 0, 1, 32'h80, 32'h0, 4'h0, rdat, er, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL lat0_rd_latency: got %0d expected 1", lat); end
      checks++; if (rdat !== 32'h76543210) begin errors++; $display("FAIL lat0_rd_data: got %h expected 76543210", rdat); end
      xact(1, 1, 0, 32'h2000, 32'h1, 4'hF, rdat, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL lat0_oor_error: got %b expected 1", er); end
   endtask

   initial begin
      errors = 0; checks = 0;
      reset = 1'b1; v = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0; rr = 1'b1;
      addr = 32'd0; wdata = 32'd0; wmask = 4'd0;
      test_reset;
      test_write_read;
      test_partial;
      test_back_to_back;
      test_backpressure;
      test_out_of_range;
      test_null_priority;
      test_reset_mid;
      test_misalign;
      test_latency0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
